// File: rtl/dbc_host_port_fsm.sv
`default_nettype none
// ============================================================================
// Module      : dbc_host_port_fsm
// Description : Host root-port state machine paired with a DbC device port.
//               Debounces device attach, drives bus reset, enables the port,
//               reports link errors and keeps the sticky change bits
//               {CEC,PLC,PRC,CSC} consumed by the port status register block.
// Ports       : clock, reset_n (async, active low)
//               port_power, dev_present, link_ok, link_err,
//               port_reset_req, port_disable_req, chg_clr[3:0]  (inputs)
//               ccs, ped, pr, chg[3:0], port_change, bus_reset,
//               state[2:0]                                      (outputs)
// Option      : DBC_HOST_AUTO_RESET_EN - when defined, ATTACHED moves to
//               RESETTING on the following edge without port_reset_req.
// Revision    : 1.0 - initial release
// ============================================================================
module dbc_host_port_fsm #(
  parameter int DEBOUNCE_CYCLES = 100,
  parameter int RESET_CYCLES    = 50,
  parameter int CNT_W           = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       port_power,
  input  logic       dev_present,
  input  logic       link_ok,
  input  logic       link_err,
  input  logic       port_reset_req,
  input  logic       port_disable_req,
  input  logic [3:0] chg_clr,
  output logic       ccs,
  output logic       ped,
  output logic       pr,
  output logic [3:0] chg,
  output logic       port_change,
  output logic       bus_reset,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_OFF          = 3'd0,
    ST_DISCONNECTED = 3'd1,
    ST_ATTACHED     = 3'd2,
    ST_RESETTING    = 3'd3,
    ST_ENABLED      = 3'd4,
    ST_ERROR        = 3'd5,
    ST_DISABLED     = 3'd6
  } state_t;

  // Bit positions inside chg
  localparam int CSC = 0;
  localparam int PRC = 1;
  localparam int PLC = 2;
  localparam int CEC = 3;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);

  state_t           cur_state;
  logic [CNT_W-1:0] cnt;

  // The async reset clears bus_reset directly, so line reset signalling
  // stops the moment reset_n falls.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur_state <= ST_OFF;
      cnt       <= '0;
      ccs       <= 1'b0;
      ped       <= 1'b0;
      pr        <= 1'b0;
      bus_reset <= 1'b0;
      chg       <= 4'b0000;
    end else if (!port_power) begin
      cur_state <= ST_OFF;
      cnt       <= '0;
      ccs       <= 1'b0;
      ped       <= 1'b0;
      pr        <= 1'b0;
      bus_reset <= 1'b0;
      chg       <= 4'b0000;
    end else begin
      // Clear first; any individual bit set below is a later assignment
      // to that bit and therefore overrides the clear (set wins).
      chg <= chg & ~chg_clr;

      case (cur_state)
        ST_OFF: begin
          cur_state <= ST_DISCONNECTED;
          cnt       <= '0;
        end

        ST_DISCONNECTED: begin
          if (!dev_present) begin
            cnt <= '0;
          end else if (cnt == DEB_LAST) begin
            ccs       <= 1'b1;
            chg[CSC]  <= 1'b1;
            cur_state <= ST_ATTACHED;
            cnt       <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_ATTACHED: begin
          if (!dev_present) begin
            ccs       <= 1'b0;
            chg[CSC]  <= 1'b1;
            cur_state <= ST_DISCONNECTED;
            cnt       <= '0;
`ifdef DBC_HOST_AUTO_RESET_EN
          end else begin
`else
          end else if (port_reset_req) begin
`endif
            pr        <= 1'b1;
            bus_reset <= 1'b1;
            cur_state <= ST_RESETTING;
            cnt       <= '0;
          end
        end

        ST_RESETTING: begin
          if (!dev_present) begin
            // Aborted reset: connect change only, no reset-complete change.
            ccs       <= 1'b0;
            pr        <= 1'b0;
            bus_reset <= 1'b0;
            chg[CSC]  <= 1'b1;
            cur_state <= ST_DISCONNECTED;
            cnt       <= '0;
          end else if (cnt == RST_LAST) begin
            pr        <= 1'b0;
            bus_reset <= 1'b0;
            chg[PRC]  <= 1'b1;
            cnt       <= '0;
            if (link_ok) begin
              ped       <= 1'b1;
              cur_state <= ST_ENABLED;
            end else begin
              chg[CEC]  <= 1'b1;
              cur_state <= ST_ERROR;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_ENABLED: begin
          if (!dev_present) begin
            ccs       <= 1'b0;
            ped       <= 1'b0;
            chg[CSC]  <= 1'b1;
            cur_state <= ST_DISCONNECTED;
            cnt       <= '0;
          end else if (link_err) begin
            ped       <= 1'b0;
            chg[PLC]  <= 1'b1;
            chg[CEC]  <= 1'b1;
            cur_state <= ST_ERROR;
          end else if (port_disable_req) begin
            ped       <= 1'b0;
            cur_state <= ST_DISABLED;
          end
        end

        ST_ERROR, ST_DISABLED: begin
          if (!dev_present) begin
            ccs       <= 1'b0;
            chg[CSC]  <= 1'b1;
            cur_state <= ST_DISCONNECTED;
            cnt       <= '0;
          end else if (port_reset_req) begin
            pr        <= 1'b1;
            bus_reset <= 1'b1;
            cur_state <= ST_RESETTING;
            cnt       <= '0;
          end
        end

        default: begin
          cur_state <= ST_OFF;
          cnt       <= '0;
        end
      endcase
    end
  end

  assign port_change = |chg;
  assign state       = cur_state;

endmodule
`default_nettype wire

// File: tb/tb_dbc_host_port_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_dbc_host_port_fsm
// Description : Self-checking bench for dbc_host_port_fsm with
//               DEBOUNCE_CYCLES=4 and RESET_CYCLES=8. A behavioural port
//               model is compared against the DUT every cycle, and directed
//               literal expectations pin key points of the scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dbc_host_port_fsm;

  localparam int DEB = 4;
  localparam int RST = 8;
`ifdef DBC_HOST_AUTO_RESET_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       port_power = 1'b0;
  logic       dev_present = 1'b0;
  logic       link_ok = 1'b0;
  logic       link_err = 1'b0;
  logic       port_reset_req = 1'b0;
  logic       port_disable_req = 1'b0;
  logic [3:0] chg_clr = 4'b0000;
  logic       ccs, ped, pr, port_change, bus_reset;
  logic [3:0] chg;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  dbc_host_port_fsm #(
    .DEBOUNCE_CYCLES(DEB),
    .RESET_CYCLES   (RST),
    .CNT_W          (16)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .port_power      (port_power),
    .dev_present     (dev_present),
    .link_ok         (link_ok),
    .link_err        (link_err),
    .port_reset_req  (port_reset_req),
    .port_disable_req(port_disable_req),
    .chg_clr         (chg_clr),
    .ccs             (ccs),
    .ped             (ped),
    .pr              (pr),
    .chg             (chg),
    .port_change     (port_change),
    .bus_reset       (bus_reset),
    .state           (state)
  );

  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  // run     : number of consecutive high dev_present cycles seen
  // elapsed : number of completed bus-reset cycles
  typedef struct packed {
    int       st;
    bit       ccs;
    bit       ped;
    bit       pr;
    bit       bus;
    bit [3:0] chg;
    int       run;
    int       elapsed;
  } model_t;

  model_t m;

  function automatic model_t model_next(input model_t c);
    model_t   n;
    bit [3:0] set;
    bit       begin_reset;
    n = c;
    set = 4'b0000;
    begin_reset = 1'b0;
    if (!port_power) begin
      n = '0;
      return n;
    end
    case (c.st)
      0: begin n.st = 1; n.run = 0; end
      1: begin
        n.run = dev_present ? c.run + 1 : 0;
        if (n.run == DEB) begin
          n.ccs = 1'b1; set[0] = 1'b1; n.st = 2; n.run = 0;
        end
      end
      2: begin
        if (!dev_present) begin
          n.ccs = 1'b0; set[0] = 1'b1; n.st = 1; n.run = 0;
        end else if (AUTO || port_reset_req) begin
          begin_reset = 1'b1;
        end
      end
      3: begin
        if (!dev_present) begin
          n.ccs = 1'b0; n.pr = 1'b0; n.bus = 1'b0; set[0] = 1'b1; n.st = 1; n.run = 0;
        end else begin
          n.elapsed = c.elapsed + 1;
          if (n.elapsed == RST) begin
            n.pr = 1'b0; n.bus = 1'b0; set[1] = 1'b1;
            if (link_ok) begin n.ped = 1'b1; n.st = 4; end
            else begin set[3] = 1'b1; n.st = 5; end
          end
        end
      end
      4: begin
        if (!dev_present) begin
          n.ccs = 1'b0; n.ped = 1'b0; set[0] = 1'b1; n.st = 1; n.run = 0;
        end else if (link_err) begin
          n.ped = 1'b0; set[3:2] = 2'b11; n.st = 5;
        end else if (port_disable_req) begin
          n.ped = 1'b0; n.st = 6;
        end
      end
      5, 6: begin
        if (!dev_present) begin
          n.ccs = 1'b0; set[0] = 1'b1; n.st = 1; n.run = 0;
        end else if (port_reset_req) begin
          begin_reset = 1'b1;
        end
      end
      default: n.st = 0;
    endcase
    if (begin_reset) begin
      n.pr = 1'b1; n.bus = 1'b1; n.st = 3; n.elapsed = 0;
    end
    n.chg = (c.chg & ~chg_clr) | set;
    return n;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) m <= '0;
    else          m <= model_next(m);
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("model_state",       int'(state),       m.st);
      chk("model_ccs",         int'(ccs),         int'(m.ccs));
      chk("model_ped",         int'(ped),         int'(m.ped));
      chk("model_pr",          int'(pr),          int'(m.pr));
      chk("model_bus_reset",   int'(bus_reset),   int'(m.bus));
      chk("model_chg",         int'(chg),         int'(m.chg));
      chk("model_port_change", int'(port_change), int'(|m.chg));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_state(input string name, input int s, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (int'(state) == s) break;
      step();
    end
    chk(name, int'(state), s);
  endtask

  // Issue a port reset request and count how many cycles pr stays high.
  task automatic reset_and_count(output int n);
    port_reset_req = 1'b1;
    step();
    port_reset_req = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!pr) break;
      n++;
      step();
    end
  endtask

  task automatic attach_from_disconnected();
    dev_present = 1'b1;
    step(DEB);
    chk("attach_state", int'(state), 2);
  endtask

  task automatic async_reset_check();
    chk("pre_areset_bus_reset", int'(bus_reset), 1);
    #1 reset_n = 1'b0;
    #1;
    chk("areset_bus_reset", int'(bus_reset), 0);
    chk("areset_pr",        int'(pr),        0);
    chk("areset_state",     int'(state),     0);
    step();
    reset_n = 1'b1;
    step();
    chk("post_areset_state", int'(state), 1);
  endtask

  int pr_len;

  initial begin
    // Reset
    step(3);
    chk("reset_state", int'(state), 0);
    chk("reset_chg",   int'(chg),   0);
    chk("reset_bus",   int'(bus_reset), 0);
    chk_en  = 1'b1;
    reset_n = 1'b1;
    step();

    // Power on
    port_power = 1'b1;
    step();
    chk("power_on_state", int'(state), 1);

    // Debounce: 3 high, 1 low, then 4 high
    dev_present = 1'b1;
    step(3);
    dev_present = 1'b0;
    step();
    dev_present = 1'b1;
    step(3);
    chk("debounce_not_yet_ccs", int'(ccs), 0);
    step();
    chk("debounce_ccs",   int'(ccs),   1);
    chk("debounce_chg",   int'(chg),   4'b0001);
    chk("debounce_state", int'(state), 2);

`ifdef DBC_HOST_AUTO_RESET_EN
    step();
    chk("auto_reset_state", int'(state), 3);
    chk("auto_reset_pr",    int'(pr),    1);
    link_ok = 1'b1;
    step(2);
    async_reset_check();
`else
    // Acknowledge CSC
    chg_clr = 4'b0001;
    step();
    chg_clr = 4'b0000;
    chk("csc_cleared", int'(chg), 0);

    // Reset to enable
    link_ok = 1'b1;
    reset_and_count(pr_len);
    chk("reset_pr_len", pr_len,      RST);
    chk("enable_state", int'(state), 4);
    chk("enable_ped",   int'(ped),   1);
    chk("enable_chg",   int'(chg),   4'b0010);

    // Link error
    link_err = 1'b1;
    step();
    link_err = 1'b0;
    chk("linkerr_state",  int'(state),     5);
    chk("linkerr_chg32",  int'(chg[3:2]),  2'b11);
    chg_clr = 4'b1111;
    step();

    // Reset failure with CEC clear colliding with the new CEC set
    link_ok = 1'b0;
    chg_clr = 4'b1000;
    reset_and_count(pr_len);
    chg_clr = 4'b0000;
    chk("fail_pr_len", pr_len,      RST);
    chk("fail_state",  int'(state), 5);
    chk("fail_ped",    int'(ped),   0);
    chk("fail_chg",    int'(chg),   4'b1010);
    chg_clr = 4'b1100;
    step();
    chk("clear_chg32", int'(chg[3:2]), 0);
    chg_clr = 4'b0010;
    step();
    chg_clr = 4'b0000;

    // Recover, then disconnect at reset cycle 3
    link_ok = 1'b1;
    port_reset_req = 1'b1;
    step();
    port_reset_req = 1'b0;
    chk("recover_state", int'(state), 3);
    step(2);
    dev_present = 1'b0;
    step();
    chk("midreset_state", int'(state), 1);
    chk("midreset_ccs",   int'(ccs),   0);
    chk("midreset_pr",    int'(pr),    0);
    chk("midreset_chg",   int'(chg),   4'b0001);

    // Reattach, enable, disable, re-enable, power off
    chg_clr = 4'b0001;
    step();
    chg_clr = 4'b0000;
    attach_from_disconnected();
    port_reset_req = 1'b1;
    step();
    port_reset_req = 1'b0;
    wait_state("reenable_state", 4, 20);
    port_disable_req = 1'b1;
    step();
    port_disable_req = 1'b0;
    chk("disable_state", int'(state), 6);
    chk("disable_ped",   int'(ped),   0);
    port_reset_req = 1'b1;
    step();
    port_reset_req = 1'b0;
    wait_state("from_disabled_state", 4, 20);
    port_power = 1'b0;
    step();
    chk("poweroff_state", int'(state), 0);
    chk("poweroff_outs",  int'({ccs, ped, pr, bus_reset, port_change, chg}), 0);

    // Power back, attach, start reset, then async reset mid-reset
    port_power = 1'b1;
    step();
    attach_from_disconnected();
    port_reset_req = 1'b1;
    step();
    port_reset_req = 1'b0;
    step(2);
    async_reset_check();
`endif

    step(2);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/dbc_host_port_fsm.md
Name: dbc_host_port_fsm

Overview:
- Host-side (debug host root-port) counterpart of the DbC port state machine.
- Detects device attach, debounces it, drives bus reset, enables the port and reports link errors.
- Produces the sticky change bits (CSC, PRC, PLC, CEC) and port status (CCS, PED, PR) that the DbC-side port logic and the host software consume.
- Sits between the line-state detector/link layer and the host port status register block.

Parameters:
- DEBOUNCE_CYCLES, 100: consecutive cycles dev_present must be high before attach is accepted; legal range 1..65535.
- RESET_CYCLES, 50: cycles bus_reset is held asserted; legal range 1..65535.
- CNT_W, 16: width of the shared debounce/reset counter; must hold the larger of the two parameters.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- port_power  in  1  PP; 0 forces the OFF state.
- dev_present  in  1  raw device-attach indication from the line detector.
- link_ok  in  1  link trained; sampled at reset expiry.
- link_err  in  1  single-cycle link error pulse.
- port_reset_req  in  1  single-cycle software port-reset request.
- port_disable_req  in  1  single-cycle software port-disable request.
- chg_clr  in  4  write-1-to-clear pulse for {CEC,PLC,PRC,CSC}.
- ccs  out  1  current connect status.
- ped  out  1  port enabled.
- pr  out  1  port reset in progress.
- chg  out  4  sticky change bits {CEC,PLC,PRC,CSC}.
- port_change  out  1  OR of chg.
- bus_reset  out  1  drives reset signalling on the line.
- state  out  3  current state encoding.

Behaviour:
- Reset: all outputs 0; state OFF (3'd0); counter 0.
- State encodings: OFF=0, DISCONNECTED=1, ATTACHED=2, RESETTING=3, ENABLED=4, ERROR=5, DISABLED=6.
- Outputs are registered. An input sampled at edge N is reflected after edge N.
- Event priority, highest first: port_power=0, disconnect (dev_present=0), link_err, port_reset_req, port_disable_req.
- Any state, port_power=0:
  - Go to OFF.
  - ccs, ped, pr and bus_reset go to 0.
  - chg is cleared; counter is cleared.
- OFF: port_power=1 -> DISCONNECTED.
- DISCONNECTED:
  - Counter increments while dev_present=1 and reloads 0 on any low cycle.
  - When the counter reaches DEBOUNCE_CYCLES-1 with dev_present=1: ccs=1, CSC=1 -> ATTACHED.
- ATTACHED:
  - port_reset_req -> RESETTING; pr=1, bus_reset=1, counter=0.
  - dev_present=0 -> DISCONNECTED; ccs=0, CSC=1.
- RESETTING:
  - Counter increments. At count RESET_CYCLES-1: pr=0, bus_reset=0, PRC=1.
  - If link_ok=1 at that edge -> ENABLED with ped=1; otherwise -> ERROR with CEC=1.
  - Disconnect during reset -> DISCONNECTED; ccs=0, pr=0, bus_reset=0, CSC=1; PRC is not set.
  - port_reset_req while RESETTING is ignored.
- ENABLED:
  - link_err -> ERROR; ped=0, PLC=1, CEC=1.
  - port_disable_req -> DISABLED; ped=0.
  - Disconnect -> DISCONNECTED; ccs=0, ped=0, CSC=1.
- ERROR and DISABLED:
  - port_reset_req -> RESETTING (same entry actions as from ATTACHED).
  - Disconnect -> DISCONNECTED; ccs=0, CSC=1.
- Change bits:
  - Sticky until cleared by the matching chg_clr bit.
  - If set and clear occur in the same cycle, set wins.
  - port_change is combinational OR of the registered chg.
- Asynchronous reset mid-operation: bus_reset drops immediately with reset_n low, without waiting for a clock edge.

Optional Feature:
- Macro: DBC_HOST_AUTO_RESET_EN.
- Defined: on entry to ATTACHED, the FSM goes to RESETTING on the next edge without port_reset_req. ATTACHED lasts exactly 1 cycle. Disconnect in that cycle still wins.
- Undefined: ATTACHED waits indefinitely for port_reset_req.

Test Plan:
- Debounce: DEBOUNCE_CYCLES=4; PP=1; dev_present high for 3 cycles, low 1, then high 4 -> ccs=1 and chg=4'b0001 only after the 4th continuous high cycle; state=2.
- Reset to enable: RESET_CYCLES=8; port_reset_req in ATTACHED with link_ok=1 -> pr and bus_reset high for exactly 8 cycles; then ped=1, chg[1]=1, state=4.
- Reset failure: same sequence with link_ok=0 -> state=5, ped=0, chg[3]=1, chg[1]=1.
- Disconnect mid-reset: dev_present=0 at reset cycle 3 -> state=1, ccs=0, pr=0, chg[0]=1, chg[1]=0.
- Error, clear, recover: link_err in ENABLED -> state=5, chg[3:2]=2'b11. chg_clr=4'b1000 in the same cycle as a new CEC set -> chg[3] stays 1. Next chg_clr=4'b1100 -> chg[3:2]=0. port_reset_req -> RESETTING.
- Power/reset override: port_power=0 in ENABLED -> state=0 and all outputs 0 next edge. reset_n low while RESETTING -> bus_reset=0 immediately; with DBC_HOST_AUTO_RESET_EN defined, a debounced attach reaches RESETTING 1 cycle after ATTACHED.
